// File: rtl/fabric_config_loader_pkg.sv
// Shared types and elaboration-time helpers for the fabric configuration loader.
// Counter widths and word counts are derived from the instantiating module's parameters.
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        SETTLE,
        DONE,
        ERR
    } cfg_state_t;

    // Width of a counter that runs 0 .. n-1 (never narrower than one bit).
    function automatic int unsigned ctr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of bitstream words needed to cover nb chain bits.
    function automatic int unsigned num_words(input int unsigned nb, input int unsigned ww);
        return (nb + ww - 1) / ww;
    endfunction

endpackage

// File: rtl/fabric_config_loader_if.sv
// Read-only bitstream memory port: single-cycle request strobe, pulsed read-data return.
interface fabric_config_loader_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORD_W = 32
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/fabric_config_loader_prog_clk_gen.sv
// Configuration chain clock divider: PROG_DIV clk cycles per prog_clk phase.
// Held low with the phase counter cleared whenever the enable is low.
module prog_clk_gen
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned PROG_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_end,
    output logic prog_clk
);

    localparam int unsigned PW = ctr_w(PROG_DIV);

    logic [PW-1:0] pcnt;

    assign phase_end = en && (pcnt == PW'(PROG_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt     <= '0;
            prog_clk <= 1'b0;
        end else if (!en) begin
            pcnt     <= '0;
            prog_clk <= 1'b0;
        end else if (phase_end) begin
            pcnt     <= '0;
            prog_clk <= ~prog_clk;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/fabric_config_loader.sv
// Loads the fabric configuration chain from bitstream memory, LSB-first, and
// releases the user design reset once the chain has been loaded and settled.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned NUM_BITS   = 1024,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned PROG_DIV   = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    fabric_config_loader_if.master mem,
    output logic                   prog_clk,
    output logic                   ccff_head,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   app_reset
);

    localparam int unsigned NUM_WORDS = num_words(NUM_BITS, WORD_W);
    localparam int unsigned LAST_WBIT = (NUM_BITS - 1) % WORD_W;
    localparam int unsigned WBW       = ctr_w(WORD_W);
    localparam int unsigned TOW       = ctr_w(TIMEOUT);
    localparam int unsigned STW       = ctr_w(SETTLE_CYC);

    cfg_state_t        state;
    cfg_state_t        state_nxt;

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] sh_next;
    logic [WBW-1:0]    wbit;
    logic [TOW-1:0]    tcnt;
    logic [STW-1:0]    scnt;

    logic              shift_en;
    logic              phase_end;
    logic              bit_end;
    logic              word_end;
    logic              last_bit;
    logic              timeout_hit;
    logic              settle_hit;

    assign shift_en = (state == SHIFT);

    prog_clk_gen #(
        .PROG_DIV (PROG_DIV)
    ) u_prog_clk_gen (
        .clk       (clk),
        .rst       (reset),
        .en        (shift_en),
        .phase_end (phase_end),
        .prog_clk  (prog_clk)
    );

    // A bit completes at the end of its high phase, i.e. on the prog_clk falling edge.
    assign bit_end     = phase_end && prog_clk;
    assign word_end    = (wbit == WBW'(WORD_W - 1));
    assign last_bit    = (mem.mem_addr == ADDR_W'(NUM_WORDS - 1)) && (wbit == WBW'(LAST_WBIT));
    assign timeout_hit = (tcnt == TOW'(TIMEOUT - 1));
    assign settle_hit  = (scnt == STW'(SETTLE_CYC - 1));
    assign sh_next     = shreg >> 1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                if (mem.mem_rvalid)   state_nxt = SHIFT;
                else if (timeout_hit) state_nxt = ERR;
            end
            SHIFT: begin
                if (bit_end) begin
                    if (last_bit)      state_nxt = SETTLE;
                    else if (word_end) state_nxt = FETCH;
                end
            end
            SETTLE: begin
                if (settle_hit) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state so they change with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            app_reset   <= 1'b1;
        end else begin
            state       <= state_nxt;
            mem.mem_req <= (state_nxt == FETCH) && (state != FETCH);
            busy        <= (state_nxt == FETCH) || (state_nxt == SHIFT) || (state_nxt == SETTLE);
            done        <= (state_nxt == DONE);
            error       <= (state_nxt == ERR);
            app_reset   <= (state_nxt != DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.mem_addr <= '0;
            shreg        <= '0;
            wbit         <= '0;
            tcnt         <= '0;
            scnt         <= '0;
            ccff_head    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        mem.mem_addr <= '0;
                        wbit         <= '0;
                        tcnt         <= '0;
                    end
                end
                FETCH: begin
                    if (mem.mem_rvalid) begin
                        shreg     <= mem.mem_rdata;
                        ccff_head <= mem.mem_rdata[0];
                        wbit      <= '0;
                    end else begin
                        tcnt <= tcnt + TOW'(1);
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        shreg <= sh_next;
                        if (last_bit) begin
                            scnt <= '0;
                        end else if (word_end) begin
                            mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
                            tcnt         <= '0;
                        end else begin
                            // Next bit is presented as prog_clk falls, so it is stable for the whole low phase.
                            ccff_head <= sh_next[0];
                            wbit      <= wbit + WBW'(1);
                        end
                    end
                end
                SETTLE: begin
                    scnt <= scnt + STW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: 40-bit chain, 16-bit words, 1-cycle memory.
module tb_fabric_config_loader;

    localparam int unsigned NB = 40;
    localparam int unsigned WW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned PD = 2;
    localparam int unsigned SC = 4;
    localparam int unsigned TO = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic prog_clk, ccff_head, busy, done, error, app_reset;
    logic mem_on = 1'b1;

    logic [15:0] rom [0:2];

    fabric_config_loader_if #(.ADDR_W(AW), .WORD_W(WW)) mif ();

    fabric_config_loader #(
        .NUM_BITS   (NB),
        .WORD_W     (WW),
        .ADDR_W     (AW),
        .PROG_DIV   (PD),
        .SETTLE_CYC (SC),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem       (mif),
        .prog_clk  (prog_clk),
        .ccff_head (ccff_head),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .app_reset (app_reset)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM responder.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mif.mem_rvalid <= 1'b0;
            mif.mem_rdata  <= '0;
        end else begin
            mif.mem_rvalid <= mem_on && mif.mem_req;
            if (mem_on && mif.mem_req)
                mif.mem_rdata <= (mif.mem_addr < 16'd3) ? rom[mif.mem_addr[1:0]] : 16'h0000;
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    int   cyc = 0;
    int   n_edges = 0;
    int   n_req = 0;
    int   n_done_rise = 0;
    int   last_fall = 0;
    int   done_rise = 0;
    int   ccff_viol = 0;
    logic bits [0:1023];
    logic [15:0] req_addr [0:63];
    logic prev_prog = 1'b0;
    logic prev_ccff = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prog_clk === 1'b1 && prev_prog === 1'b0 && n_edges < 1024) begin
            bits[n_edges] = ccff_head;
            n_edges++;
        end
        if (prog_clk === 1'b0 && prev_prog === 1'b1) last_fall = cyc;
        if (prog_clk === 1'b1 && prev_prog === 1'b1 && ccff_head !== prev_ccff) ccff_viol++;
        if (mif.mem_req === 1'b1 && n_req < 64) begin
            req_addr[n_req] = mif.mem_addr;
            n_req++;
        end
        if (done === 1'b1 && prev_done === 1'b0) begin
            n_done_rise++;
            done_rise = cyc;
        end
        prev_prog = prog_clk;
        prev_ccff = ccff_head;
        prev_done = done;
    end

    // Number of captured chain bits (from index base) that differ from the ROM stream.
    function automatic int bit_errors(input int base);
        int n = 0;
        logic [15:0] w;
        for (int i = 0; i < int'(NB); i++) begin
            w = rom[i / 16];
            if (bits[base + i] !== w[i % 16]) n++;
        end
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests_run++;
            if (prog_clk !== 1'b0) begin tests_failed++; $display("FAIL reset_prog_clk: got %b expected 0", prog_clk); end
            tests_run++;
            if (app_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_app_reset: got %b expected 1", app_reset); end
        end
        tests_run++;
        if ({mif.mem_req, ccff_head, busy, done, error} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req/ccff/busy/done/err=%b expected 00000",
                     {mif.mem_req, ccff_head, busy, done, error});
        end
        tests_run++;
        if (mif.mem_addr !== 16'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d expected 0", mif.mem_addr); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({busy, app_reset, mif.mem_req} !== 3'b010) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got busy/app_reset/req=%b expected 010", {busy, app_reset, mif.mem_req});
        end
    endtask

    task automatic test_full_load();
        int be = n_edges;
        int br = n_req;
        int bd = n_done_rise;
        int n = 0;
        pulse_start();
        tests_run++;
        if ({mif.mem_req, busy, app_reset, done} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL load_first_cycle: got req/busy/app_reset/done=%b expected 1110",
                     {mif.mem_req, busy, app_reset, done});
        end
        while (done !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL load_done_timeout: got done=%b expected 1", done); end
        tests_run++;
        if (n_req - br !== 3) begin tests_failed++; $display("FAIL load_req_count: got %0d expected 3", n_req - br); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (req_addr[br + k] !== 16'(k)) begin
                tests_failed++;
                $display("FAIL load_req_addr%0d: got %0d expected %0d", k, req_addr[br + k], k);
            end
        end
        tests_run++;
        if (n_edges - be !== 40) begin tests_failed++; $display("FAIL load_edges: got %0d expected 40", n_edges - be); end
        tests_run++;
        if (bit_errors(be) !== 0) begin tests_failed++; $display("FAIL load_bits: got %0d wrong bits expected 0", bit_errors(be)); end
        tests_run++;
        if (done_rise - last_fall !== 4) begin
            tests_failed++;
            $display("FAIL load_settle: got %0d cycles expected 4", done_rise - last_fall);
        end
        tests_run++;
        if ({app_reset, busy, error} !== 3'b000) begin
            tests_failed++;
            $display("FAIL load_final_status: got app_reset/busy/err=%b expected 000", {app_reset, busy, error});
        end
        tests_run++;
        if (n_done_rise - bd !== 1) begin tests_failed++; $display("FAIL load_done_rises: got %0d expected 1", n_done_rise - bd); end
        tests_run++;
        if (ccff_viol !== 0) begin tests_failed++; $display("FAIL ccff_stable_high: got %0d changes expected 0", ccff_viol); end
    endtask

    task automatic test_start_in_done();
        int be = n_edges;
        int bd = n_done_rise;
        int n = 0;
        pulse_start();
        tests_run++;
        if ({done, app_reset, mif.mem_req} !== 3'b011 || mif.mem_addr !== 16'd0) begin
            tests_failed++;
            $display("FAIL restart_from_done: got done/app_reset/req=%b addr=%0d expected 011 addr=0",
                     {done, app_reset, mif.mem_req}, mif.mem_addr);
        end
        while (done !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (n_edges - be !== 40) begin tests_failed++; $display("FAIL restart_edges: got %0d expected 40", n_edges - be); end
        tests_run++;
        if (bit_errors(be) !== 0) begin tests_failed++; $display("FAIL restart_bits: got %0d wrong bits expected 0", bit_errors(be)); end
        tests_run++;
        if (n_done_rise - bd !== 1 || app_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_done: got rises=%0d app_reset=%b expected 1 and 0", n_done_rise - bd, app_reset);
        end
    endtask

    task automatic test_start_during_shift();
        int be = n_edges;
        int br = n_req;
        int bd = n_done_rise;
        int n = 0;
        pulse_start();
        while (n_edges - be < 10 && n < 2000) begin @(negedge clk); #1; n++; end
        pulse_start();
        tests_run++;
        if (mif.mem_req !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL shift_start_ignored: got req=%b busy=%b expected 0 1", mif.mem_req, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (n_req - br !== 3) begin tests_failed++; $display("FAIL shift_req_count: got %0d expected 3", n_req - br); end
        tests_run++;
        if (n_edges - be !== 40) begin tests_failed++; $display("FAIL shift_edges: got %0d expected 40", n_edges - be); end
        tests_run++;
        if (bit_errors(be) !== 0) begin tests_failed++; $display("FAIL shift_bits: got %0d wrong bits expected 0", bit_errors(be)); end
        repeat (5) @(negedge clk);
        #1;
        tests_run++;
        if (n_done_rise - bd !== 1) begin tests_failed++; $display("FAIL shift_done_rises: got %0d expected 1", n_done_rise - bd); end
    endtask

    task automatic test_timeout();
        int be = n_edges;
        int c0;
        int n = 0;
        mem_on = 1'b0;
        pulse_start();
        c0 = cyc;
        tests_run++;
        if (mif.mem_req !== 1'b1) begin tests_failed++; $display("FAIL timeout_req: got %b expected 1", mif.mem_req); end
        while (error !== 1'b1 && n < 400) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (error !== 1'b1 || cyc - c0 !== 256) begin
            tests_failed++;
            $display("FAIL timeout_latency: got error=%b after %0d cycles expected 1 after 256", error, cyc - c0);
        end
        tests_run++;
        if ({busy, app_reset, done} !== 3'b010) begin
            tests_failed++;
            $display("FAIL timeout_status: got busy/app_reset/done=%b expected 010", {busy, app_reset, done});
        end
        tests_run++;
        if (n_edges - be !== 0) begin tests_failed++; $display("FAIL timeout_edges: got %0d expected 0", n_edges - be); end
        mem_on = 1'b1;
        be = n_edges;
        pulse_start();
        tests_run++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_clear: got error=%b busy=%b expected 0 1", error, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (n_edges - be !== 40 || bit_errors(be) !== 0) begin
            tests_failed++;
            $display("FAIL timeout_reload: got %0d edges %0d wrong bits expected 40 and 0", n_edges - be, bit_errors(be));
        end
    endtask

    task automatic test_reset_mid();
        int be = n_edges;
        int br;
        int n = 0;
        pulse_start();
        while (n_edges - be < 21 && n < 2000) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (prog_clk !== 1'b1) begin tests_failed++; $display("FAIL midreset_setup: got prog_clk=%b expected 1", prog_clk); end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({prog_clk, app_reset, busy} !== 3'b010 || mif.mem_addr !== 16'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: got prog_clk/app_reset/busy=%b addr=%0d expected 010 addr=0",
                     {prog_clk, app_reset, busy}, mif.mem_addr);
        end
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        be = n_edges;
        br = n_req;
        pulse_start();
        tests_run++;
        if (mif.mem_req !== 1'b1 || mif.mem_addr !== 16'd0) begin
            tests_failed++;
            $display("FAIL midreset_restart: got req=%b addr=%0d expected 1 addr=0", mif.mem_req, mif.mem_addr);
        end
        n = 0;
        while (done !== 1'b1 && n < 2000) begin @(negedge clk); #1; n++; end
        tests_run++;
        if (n_edges - be !== 40 || bit_errors(be) !== 0) begin
            tests_failed++;
            $display("FAIL midreset_reload: got %0d edges %0d wrong bits expected 40 and 0", n_edges - be, bit_errors(be));
        end
        tests_run++;
        if (n_req - br !== 3) begin tests_failed++; $display("FAIL midreset_req_count: got %0d expected 3", n_req - br); end
    endtask

    initial begin
        rom[0] = 16'hA5A5;
        rom[1] = 16'h0F0F;
        rom[2] = 16'h00FF;
        test_reset();
        test_full_load();
        test_start_in_done();
        test_start_during_shift();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Configuration controller for the OpenFPGA fabric (fpga_top) used by the fpga_LFSR flow.
- Fetches bitstream words from a read-only bitstream memory and serialises them LSB-first onto the fabric configuration chain (ccff_head plus a generated prog_clk).
- Holds the mapped design in reset until the chain is fully loaded and settled, then releases it.
- Sits between the bitstream ROM and fpga_top in the full (non-formal) testbench and the board-level top.

Parameters:
- NUM_BITS, 1024, configuration chain length in bits; must be ≥1.
- WORD_W, 32, bitstream memory word width.
- ADDR_W, 16, memory address width; must satisfy ceil(NUM_BITS/WORD_W) ≤ 2^ADDR_W.
- PROG_DIV, 2, clk cycles per prog_clk phase; must be ≥1. One bit takes 2*PROG_DIV cycles.
- SETTLE_CYC, 4, clk cycles between the last prog_clk falling edge and done.
- TIMEOUT, 256, maximum clk cycles from mem_req to mem_rvalid before error.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle load request.
- mem_req  out  1  single-cycle read strobe.
- mem_addr  out  ADDR_W  word address; valid when mem_req=1.
- mem_rvalid  in  1  read data valid (pulse).
- mem_rdata  in  WORD_W  read data; sampled when mem_rvalid=1.
- prog_clk  out  1  configuration chain clock to the fabric.
- ccff_head  out  1  configuration chain serial data.
- busy  out  1  load in progress.
- done  out  1  chain loaded and settled; sticky until the next start.
- error  out  1  memory timeout; sticky until the next start or reset.
- app_reset  out  1  reset to the mapped user design; active-high.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values: mem_req=0, mem_addr=0, prog_clk=0, ccff_head=0, busy=0, done=0, error=0, app_reset=1, state=IDLE.
- States: IDLE, FETCH, SHIFT, SETTLE, DONE, ERR.
- IDLE/DONE/ERR, start=1:
  - next cycle: state=FETCH, mem_req=1, mem_addr=0, busy=1;
  - done=0, error=0, app_reset=1; bit and word counters cleared.
- start is ignored in FETCH, SHIFT and SETTLE.
- FETCH:
  - mem_req is high for exactly one cycle.
  - The timeout counter starts on the mem_req cycle.
  - On mem_rvalid=1, capture mem_rdata into the shift register and go to SHIFT on the next cycle.
  - If TIMEOUT cycles pass without mem_rvalid, go to ERR: error=1, busy=0, app_reset stays 1.
  - mem_rvalid in any state other than FETCH is ignored.
- SHIFT, per bit:
  - ccff_head = current LSB, prog_clk=0 for PROG_DIV cycles;
  - then prog_clk=1 for PROG_DIV cycles. The fabric captures ccff_head on the prog_clk rising edge.
  - ccff_head changes only while prog_clk=0.
- Bit order: bit 0 of word 0 is shifted first; within a word, LSB first.
- After the last bit of a word (before NUM_BITS is reached): prog_clk returns to 0, mem_addr increments, go to FETCH.
- The final word is partial when NUM_BITS mod WORD_W ≠ 0; its unused upper bits are never shifted.
- After bit NUM_BITS-1: prog_clk=0, go to SETTLE.
  - Exactly NUM_BITS prog_clk rising edges occur per load.
- SETTLE: count SETTLE_CYC cycles, then go to DONE: done=1, busy=0, app_reset=0.
- prog_clk=0 in every state except the high phase of SHIFT. ccff_head holds its last value outside SHIFT.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). No partial prog_clk pulse is completed. A new start reloads from bit 0.
- Cycle cost per load:
  - each word: 1 (mem_req) + memory latency + 1 (capture) cycles;
  - each bit: 2*PROG_DIV cycles;
  - plus SETTLE_CYC.

Decomposition:
- Package fabric_cfg_pkg holds:
  - the state enum cfg_state_t;
  - the derived constant NUM_WORDS = ceil(NUM_BITS/WORD_W);
  - helper functions for counter widths (clog2 of NUM_BITS, PROG_DIV, TIMEOUT, SETTLE_CYC).
- One sub-module, prog_clk_gen: a PROG_DIV phase divider with an enable input. Outputs are a phase-end strobe and prog_clk. Clears to low when the enable drops or on reset.

Test Plan:
- Reset: hold reset for 3 cycles → all outputs at their reset values, app_reset=1, prog_clk=0 throughout.
- Full load (NUM_BITS=40, WORD_W=16, PROG_DIV=2, SETTLE_CYC=4, 1-cycle memory returning 0xA5A5, 0x0F0F, 0x00FF) →
  - 3 mem_req pulses with mem_addr 0, 1, 2;
  - exactly 40 prog_clk rising edges; ccff_head sampled at those edges = LSB-first bits of 0xA5A5, then 0x0F0F, then bits 0–7 of 0x00FF;
  - done=1 and app_reset=0 exactly 4 cycles after the final prog_clk falling edge.
- start pulsed during SHIFT at bit 10 → no extra mem_req, still exactly 40 edges, single done rise.
- Memory never asserts mem_rvalid → error=1 exactly 256 cycles after mem_req, busy=0, app_reset=1, zero prog_clk edges; a later start clears error and runs a normal load.
- reset asserted mid-cycle at bit 20 → prog_clk=0 and app_reset=1 immediately; then start → mem_addr=0 and 40 fresh edges starting from bit 0 of 0xA5A5.
- start in DONE → app_reset=1 and done=0 on the next cycle; an identical 40-edge sequence follows, then done=1 again.
